// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM port arbiter: FSM states, access sizes
// and the default anti-starvation threshold.
package ram_arb_pkg;

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_RESP   = 1'b1
    } arb_state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage : ram_arb_pkg

// File: rtl/ram_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles in which a pending debug request
// was refused; at_max tells the arbiter to force the debug port in.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic at_max
);

    logic [W-1:0] cnt_r;

    // Hold wins over clear, clear wins over increment; increment saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != W'(MAX))) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == W'(MAX));

endmodule : starve_counter

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single data RAM between the CPU MEM stage (priority) and a
// valid/ready debug port that is forced in after STARVE_MAX refused cycles.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic              cpu_se,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_rw,
    input  logic              dbg_se,
    input  logic [1:0]        dbg_size,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_e,
    output logic              ram_rw,
    output logic              ram_se,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic              grant_dbg_s;
    logic              at_max_s;
    logic              cnt_inc_s;
    logic              cnt_clr_s;
    logic              cnt_hold_s;
    logic [DATA_W-1:0] dbg_rdata_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_NORMAL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant decision and next state; the debug port is only granted in S_NORMAL
    // and never while reset is asserted.
    always_comb begin
        state_nxt_s = state_r;
        grant_dbg_s = 1'b0;
        case (state_r)
            S_NORMAL: begin
                grant_dbg_s = reset && dbg_valid && (!cpu_req || at_max_s);
                if (grant_dbg_s && !dbg_rw) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_NORMAL;
                end
            end
            S_RESP: begin
                state_nxt_s = S_NORMAL;
            end
            default: begin
                state_nxt_s = S_NORMAL;
            end
        endcase
    end

    // RAM port mux: debug fields only on a grant, otherwise the CPU owns the RAM.
    always_comb begin
        ram_e     = 1'b0;
        ram_rw    = cpu_rw;
        ram_se    = cpu_se;
        ram_size  = cpu_size;
        ram_addr  = cpu_addr;
        ram_din   = cpu_wdata;
        dbg_ready = 1'b0;
        cpu_stall = 1'b0;
        if (grant_dbg_s) begin
            ram_e     = 1'b1;
            ram_rw    = dbg_rw;
            ram_se    = dbg_se;
            ram_size  = dbg_size;
            ram_addr  = dbg_addr;
            ram_din   = dbg_wdata;
            dbg_ready = 1'b1;
            cpu_stall = cpu_req;
        end else begin
            ram_e     = reset && cpu_req;
        end
    end

    // Starvation counter control: counting only happens while in S_NORMAL.
    always_comb begin
        cnt_hold_s = (state_r == S_RESP);
        cnt_clr_s  = 1'b0;
        cnt_inc_s  = 1'b0;
        if (state_r == S_NORMAL) begin
            cnt_clr_s = grant_dbg_s || !dbg_valid;
            cnt_inc_s = dbg_valid && !grant_dbg_s;
        end else begin
            cnt_clr_s = 1'b0;
            cnt_inc_s = 1'b0;
        end
    end

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve_counter (
        .clk    (clk),
        .rst_n  (reset),
        .inc    (cnt_inc_s),
        .clr    (cnt_clr_s),
        .hold   (cnt_hold_s),
        .at_max (at_max_s)
    );

    // Capture debug read data on the accepting edge; it is presented in S_RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dbg_rdata_r <= '0;
        end else if (grant_dbg_s && !dbg_rw) begin
            dbg_rdata_r <= ram_dout;
        end else begin
            dbg_rdata_r <= dbg_rdata_r;
        end
    end

    assign dbg_rdata  = dbg_rdata_r;
    assign dbg_rvalid = (state_r == S_RESP);
    assign cpu_rdata  = ram_dout;

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a behavioural
// memory/arbitration reference model, with a behavioural RAM on the RAM port.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int SMAX = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_rw, cpu_se;
    logic [1:0]  cpu_size;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_valid, dbg_ready, dbg_rw, dbg_se;
    logic [1:0]  dbg_size;
    logic [8:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        ram_e, ram_rw, ram_se;
    logic [1:0]  ram_size;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_se(cpu_se), .cpu_size(cpu_size),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_rw(dbg_rw), .dbg_se(dbg_se),
        .dbg_size(dbg_size), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_e(ram_e), .ram_rw(ram_rw), .ram_se(ram_se), .ram_size(ram_size),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] env_mem [512];
    logic [7:0] ref_mem [512];

    function automatic logic [31:0] fmt_load(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [1:0] size, input logic se);
        case (size)
            SZ_BYTE: return se ? {{24{b0[7]}}, b0} : {24'h0, b0};
            SZ_HALF: return se ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    function automatic int nbytes(input logic [1:0] size);
        return (size == SZ_BYTE) ? 1 : ((size == SZ_HALF) ? 2 : 4);
    endfunction

    // Behavioural RAM: asynchronous little-endian read, byte-lane write on the edge.
    always_comb begin
        ram_dout = fmt_load(env_mem[ram_addr], env_mem[9'(ram_addr + 9'd1)],
                            env_mem[9'(ram_addr + 9'd2)], env_mem[9'(ram_addr + 9'd3)],
                            ram_size, ram_se);
    end

    always @(posedge clk) begin
        if (ram_e && ram_rw) begin
            for (int k = 0; k < nbytes(ram_size); k++)
                env_mem[9'(ram_addr + 9'(k))] <= ram_din[8*k +: 8];
        end
    end

    // Reference model state.
    int          n_checks = 0;
    int          n_errors = 0;
    bit          m_resp;
    int          m_wait;
    logic [31:0] m_rdata;
    bit          exp_grant, exp_stall;
    logic        obs_ready, obs_stall, obs_rvalid, obs_ram_e;
    logic [31:0] obs_rdata, obs_cpu_rdata;

    function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [1:0] size, input logic se);
        return fmt_load(ref_mem[a], ref_mem[9'(a + 9'd1)], ref_mem[9'(a + 9'd2)],
                        ref_mem[9'(a + 9'd3)], size, se);
    endfunction

    task automatic ref_store(input logic [8:0] a, input logic [1:0] size, input logic [31:0] d);
        for (int k = 0; k < nbytes(size); k++)
            ref_mem[9'(a + 9'(k))] = d[8*k +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cpu(input logic req, input logic rw, input logic se, input logic [1:0] size,
                           input logic [8:0] addr, input logic [31:0] wdata);
        cpu_req = req; cpu_rw = rw; cpu_se = se; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic set_dbg(input logic valid, input logic rw, input logic se, input logic [1:0] size,
                           input logic [8:0] addr, input logic [31:0] wdata);
        dbg_valid = valid; dbg_rw = rw; dbg_se = se; dbg_size = size; dbg_addr = addr; dbg_wdata = wdata;
    endtask

    // One cycle: inputs already set at the falling edge; check, clock, advance model.
    task automatic tick();
        bit g, st, re;
        #1;
        if (!reset) begin
            g = 0; st = 0; re = 0;
        end else if (m_resp) begin
            g = 0; st = 0; re = cpu_req;
        end else begin
            g  = dbg_valid && (!cpu_req || m_wait >= SMAX);
            st = g && cpu_req;
            re = g || cpu_req;
        end
        chk("cpu_stall", 32'(cpu_stall), 32'(st));
        chk("dbg_ready", 32'(dbg_ready), 32'(g));
        chk("ram_e", 32'(ram_e), 32'(re));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_resp));
        chk("dbg_rdata", dbg_rdata, m_rdata);
        if (re) begin
            chk("ram_addr", 32'(ram_addr), 32'(g ? dbg_addr : cpu_addr));
            chk("ram_rw", 32'(ram_rw), 32'(g ? dbg_rw : cpu_rw));
        end
        if (reset && cpu_req && !cpu_rw && !st)
            chk("cpu_rdata", cpu_rdata, ref_load(cpu_addr, cpu_size, cpu_se));
        obs_ready = dbg_ready; obs_stall = cpu_stall; obs_rvalid = dbg_rvalid;
        obs_ram_e = ram_e; obs_rdata = dbg_rdata; obs_cpu_rdata = cpu_rdata;
        exp_grant = g; exp_stall = st;
        @(posedge clk);
        if (!reset) begin
            m_resp = 0; m_wait = 0; m_rdata = 32'h0;
        end else begin
            if (g) begin
                if (dbg_rw) ref_store(dbg_addr, dbg_size, dbg_wdata);
                else        m_rdata = ref_load(dbg_addr, dbg_size, dbg_se);
            end else if (cpu_req && cpu_rw) begin
                ref_store(cpu_addr, cpu_size, cpu_wdata);
            end
            if (m_resp) begin
                m_resp = 0;
            end else begin
                m_resp = g && !dbg_rw;
                if (g || !dbg_valid) m_wait = 0;
                else if (m_wait < SMAX) m_wait++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        m_resp = 0; m_wait = 0; m_rdata = 32'h0;
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, 1'b0, 2'b00, 9'h000, 32'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 2'b00, 9'h000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        chk("rst_rvalid", 32'(obs_rvalid), 32'h0);
        chk("rst_rdata", obs_rdata, 32'h0);

        // 1: idle CPU, debug word write then read back.
        reset = 1'b1;
        set_dbg(1'b1, 1'b1, 1'b0, SZ_WORD, 9'h040, 32'hDEADBEEF); tick();
        chk("t1_wr_ready", 32'(obs_ready), 32'h1);
        set_dbg(1'b1, 1'b0, 1'b0, SZ_WORD, 9'h040, 32'h0); tick();
        chk("t1_rd_ready", 32'(obs_ready), 32'h1);
        set_dbg(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0); tick();
        chk("t1_rvalid", 32'(obs_rvalid), 32'h1);
        chk("t1_rdata", obs_rdata, 32'hDEADBEEF);
        chk("t1_stall", 32'(obs_stall), 32'h0);

        // 2: continuous CPU reads; debug forced in on the 5th cycle, twice in a row.
        set_cpu(1'b1, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        for (int r = 0; r < 2; r++) begin
            set_dbg(1'b1, 1'b1, 1'b0, SZ_WORD, 9'(9'h080 + 9'(4 * r)), 32'hA5A50000 + 32'(r));
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("t2_ready", 32'(obs_ready), 32'(i == 4));
                chk("t2_stall", 32'(obs_stall), 32'(i == 4));
            end
        end
        set_dbg(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);

        // 3: CPU store served during the debug read response cycle.
        set_cpu(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        set_dbg(1'b1, 1'b0, 1'b0, SZ_WORD, 9'h010, 32'h0); tick();
        set_dbg(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        set_cpu(1'b1, 1'b1, 1'b0, SZ_WORD, 9'h020, 32'h12345678); tick();
        chk("t3_stall", 32'(obs_stall), 32'h0);
        chk("t3_rvalid", 32'(obs_rvalid), 32'h1);
        set_cpu(1'b1, 1'b0, 1'b0, SZ_WORD, 9'h020, 32'h0); tick();
        chk("t3_cpu_rd", obs_cpu_rdata, 32'h12345678);

        // 4: debug byte write then sign-extended CPU byte read.
        set_cpu(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        set_dbg(1'b1, 1'b1, 1'b0, SZ_BYTE, 9'h003, 32'h000000AB); tick();
        set_dbg(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        set_cpu(1'b1, 1'b0, 1'b1, SZ_BYTE, 9'h003, 32'h0); tick();
        chk("t4_cpu_rd", obs_cpu_rdata, 32'hFFFFFFAB);

        // 5: reset while a read response is pending.
        set_cpu(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        set_dbg(1'b1, 1'b0, 1'b0, SZ_WORD, 9'h040, 32'h0); tick();
        reset = 1'b0;
        set_cpu(1'b1, 1'b1, 1'b0, SZ_WORD, 9'h060, 32'h0BADF00D);
        set_dbg(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0); tick();
        chk("t5_ram_e_a", 32'(obs_ram_e), 32'h0);
        set_dbg(1'b1, 1'b0, 1'b0, SZ_WORD, 9'h040, 32'h0); tick();
        chk("t5_rvalid", 32'(obs_rvalid), 32'h0);
        chk("t5_rdata", obs_rdata, 32'h0);
        chk("t5_ram_e", 32'(obs_ram_e), 32'h0);
        chk("t5_ready", 32'(obs_ready), 32'h0);
        reset = 1'b1;
        set_cpu(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        set_dbg(1'b1, 1'b1, 1'b0, SZ_WORD, 9'h044, 32'h55AA33CC); tick();
        chk("t5_after_ready", 32'(obs_ready), 32'h1);

        // 6: a one-cycle drop of dbg_valid restarts the starvation wait.
        set_cpu(1'b1, 1'b0, 1'b0, SZ_HALF, 9'h002, 32'h0);
        set_dbg(1'b1, 1'b1, 1'b0, SZ_WORD, 9'h048, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_denied", 32'(obs_ready), 32'h0);
        end
        dbg_valid = 1'b0; tick();
        dbg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_ready", 32'(obs_ready), 32'(i == 4));
        end

        // Random traffic with handshake-legal debug requests and CPU retries.
        set_dbg(1'b0, 1'b0, 1'b0, SZ_WORD, 9'h000, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 59) != 0);
            if (!exp_stall)
                set_cpu(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                        2'($urandom_range(0, 2)), 9'($urandom_range(0, 63)), $urandom);
            if (dbg_valid && !exp_grant) begin
                if ($urandom_range(0, 15) == 0) dbg_valid = 1'b0;
            end else begin
                set_dbg(1'($urandom), 1'($urandom), 1'($urandom),
                        2'($urandom_range(0, 2)), 9'($urandom_range(0, 63)), $urandom);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ram_port_arbiter

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single data RAM (512 bytes, 9-bit byte address, async read, write on clock edge) between two requesters.
- The requesters are the CPU MEM stage and a debug/loader port with a valid/ready handshake.
- The CPU has priority. The debug port is protected from starvation by a saturating wait counter.
- When the debug port is forced in, the arbiter raises cpu_stall. The hazard/forwarding unit uses cpu_stall to drop load_enable and to freeze the EX/MEM register for that cycle.

Parameters:
- ADDR_W, 9, RAM byte-address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive denied debug cycles before the debug port is forced in (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- cpu_req  in  1  MEM-stage RAM enable (mem control E bit)
- cpu_rw  in  1  1 = write, 0 = read
- cpu_se  in  1  sign-extend on read
- cpu_size  in  2  00 byte, 01 half, 10 word
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data (RAM dout passthrough)
- cpu_stall  out  1  MEM stage must hold this cycle
- dbg_valid  in  1  debug request pending
- dbg_ready  out  1  debug request accepted this cycle
- dbg_rw, dbg_se, dbg_size, dbg_addr, dbg_wdata  in  1/1/2/ADDR_W/DATA_W  same meaning as the cpu_* fields
- dbg_rvalid  out  1  read data valid (one-cycle pulse)
- dbg_rdata  out  DATA_W  registered read data
- ram_e, ram_rw, ram_se  out  1 each  to RAM
- ram_size  out  2  to RAM
- ram_addr  out  ADDR_W  to RAM
- ram_din  out  DATA_W  to RAM
- ram_dout  in  DATA_W  from RAM

Behaviour:
- States:
  - S_NORMAL: accepting requests.
  - S_RESP: debug read response cycle.
- Grant rule (combinational, S_NORMAL only): grant_dbg = dbg_valid && (!cpu_req || starve_cnt == STARVE_MAX).
- Mux:
  - When grant_dbg=1, the RAM fields come from dbg_* and dbg_ready=1.
  - Otherwise the RAM fields come from cpu_*, and ram_e = cpu_req.
  - cpu_rdata = ram_dout in every cycle. Its value is meaningful only when the CPU is not stalled.
- cpu_stall = grant_dbg && cpu_req. The CPU request is retried unchanged the next cycle.
- Handshake:
  - A transfer occurs on the edge where dbg_valid && dbg_ready.
  - dbg_* fields must stay stable while dbg_valid=1 and dbg_ready=0.
  - dbg_ready=0 in S_RESP, so only one debug read is outstanding.
- Transitions:
  - S_NORMAL→S_RESP on a granted debug read. dbg_rdata <= ram_dout at that edge.
  - S_RESP→S_NORMAL unconditionally after one cycle. dbg_rvalid=1 exactly in S_RESP.
  - A granted debug write stays in S_NORMAL. The RAM writes at that edge and dbg_rvalid is not raised.
- starve_cnt (log2(STARVE_MAX+1) bits):
  - Increments on each S_NORMAL cycle with dbg_valid && !grant_dbg, saturating at STARVE_MAX.
  - Clears on grant_dbg or when dbg_valid=0.
  - Holds in S_RESP.
- CPU in S_RESP: the CPU is served normally and never stalled.
- Latencies:
  - Debug write: 0 cycles when the CPU is idle; at most STARVE_MAX cycles of waiting under continuous CPU traffic.
  - Debug read: data arrives 1 cycle after acceptance.
- Reset (reset=0 at the edge):
  - state=S_NORMAL, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0.
  - While reset=0: ram_e=0, dbg_ready=0, cpu_stall=0, and a pending read response is discarded.
- Simultaneous same-address access: cannot occur, because only one requester drives the RAM per cycle. A debug write followed by a CPU read of the same address returns the new data.

Decomposition:
- Package ram_arb_pkg holds:
  - the state encoding (S_NORMAL, S_RESP)
  - the size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - the default STARVE_MAX
- Sub-module starve_counter: saturating counter with inc, clr and hold inputs and an at_max output.
- The FSM and muxing stay in ram_port_arbiter.

Test Plan:
1. CPU idle; debug write of 0xDEADBEEF, word size, address 0x040; then debug read of 0x040 → dbg_ready=1 in the same cycle as the write; dbg_rvalid pulses 1 cycle after the read is accepted with dbg_rdata=0xDEADBEEF; cpu_stall stays 0.
2. cpu_req held high continuously, reads of address 0x000; dbg_valid held high with STARVE_MAX=4 → dbg_ready low for exactly 4 cycles and high on the 5th; cpu_stall=1 only in that 5th cycle; starve_cnt returns to 0.
3. Debug read of address 0x010 granted while the CPU is idle, then a CPU word store of 0x12345678 to address 0x020 during S_RESP → cpu_stall=0 and the store completes; a following CPU read of address 0x020 returns 0x12345678.
4. Debug byte write of 0x000000AB to address 0x003, then CPU byte read of address 0x003 with se=1 → cpu_rdata=0xFFFFFFAB.
5. reset driven to 0 while in S_RESP → next cycle dbg_rvalid=0, dbg_rdata=0, ram_e=0, dbg_ready=0; after reset returns to 1, a new debug request is accepted normally.
6. dbg_valid toggled off for one cycle after 3 denied cycles → starve_cnt clears; 4 further denied cycles are needed before the debug port is forced in.
